cmd_registry: RTL

CMD_REGISTRY -- requirements
Module: cmd_registry

---
 rtl/cmd_registry.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cmd_registry.sv
// rtl/cmd_registry.sv - command FIFO with time-gated one-per-request issue FSM
module cmd_registry #(
   parameter int DEPTH = 8,
   parameter int LEAD  = 16
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      CLR,
   input  logic                      CMD_WR,
   input  logic [47:0]               CMD_DDS_freq,
   input  logic [47:0]               CMD_DDS_delta_freq,
   input  logic [31:0]               CMD_DDS_delta_rate,
   input  logic [47:0]               CMD_TIME_START,
   input  logic [15:0]               CMD_N_impuls,
   input  logic [1:0]                CMD_TYPE_impulse,
   input  logic [31:0]               CMD_Interval_Ti,
   input  logic [31:0]               CMD_Interval_Tp,
   input  logic [31:0]               CMD_Tblank1,
   input  logic [31:0]               CMD_Tblank2,
   input  logic [63:0]               TIME,
   input  logic                      REQ_COMMAND,
   output logic                      WR_DATA,
   output logic [47:0]               MEM_DDS_freq,
   output logic [47:0]               MEM_DDS_delta_freq,
   output logic [31:0]               MEM_DDS_delta_rate,
   output logic [47:0]               MEM_TIME_START,
   output logic [15:0]               MEM_N_impuls,
   output logic [1:0]                MEM_TYPE_impulse,
   output logic [31:0]               MEM_Interval_Ti,
   output logic [31:0]               MEM_Interval_Tp,
   output logic [31:0]               MEM_Tblank1,
   output logic [31:0]               MEM_Tblank2,
   output logic                      FULL,
   output logic                      EMPTY,
   output logic [$clog2(DEPTH):0]    LEVEL,
   output logic                      OVERFLOW,
   output logic [15:0]               DROP_CNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int W  = 322;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CHECK,
      S_ISSUE,
      S_WAIT_LOW
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic            overflow_q, overflow_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic [W-1:0]    mem_out_q, mem_out_d;
   logic [W-1:0]    ram_q [DEPTH];
   logic [W-1:0]    cmd_in;
   logic [W-1:0]    head;
   logic [47:0]     deadline;
   logic            push;
   logic            pop;
   logic            stale;
   logic            unused_time_hi;

   assign cmd_in = {CMD_DDS_freq, CMD_DDS_delta_freq, CMD_DDS_delta_rate, CMD_TIME_START,
                    CMD_N_impuls, CMD_TYPE_impulse, CMD_Interval_Ti, CMD_Interval_Tp,
                    CMD_Tblank1, CMD_Tblank2};

   assign {MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate, MEM_TIME_START,
           MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti, MEM_Interval_Tp,
           MEM_Tblank1, MEM_Tblank2} = mem_out_q;

   assign unused_time_hi = ^TIME[63:48];
   assign head           = ram_q[rd_ptr_q];
   // Sum wraps mod 2^48 on purpose; no compensation near the top of the time range.
   assign deadline       = TIME[47:0] + 48'(LEAD);
   assign stale          = MEM_TIME_START < deadline;

   assign FULL     = (level_q == (AW+1)'(DEPTH));
   assign EMPTY    = (level_q == '0);
   assign LEVEL    = level_q;
   assign OVERFLOW = overflow_q;
   assign DROP_CNT = drop_cnt_q;
   assign WR_DATA  = (state_q == S_ISSUE);

   // A full queue rejects a push even when a pop happens in the same cycle.
   assign push = CMD_WR && !FULL && !CLR;

   always_ff @(posedge CLK) begin
      if (push) begin
         ram_q[wr_ptr_q] <= cmd_in;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_out_d  = mem_out_q;
      drop_cnt_d = drop_cnt_q;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (REQ_COMMAND && !EMPTY) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_out_d = head;
            state_d   = S_CHECK;
         end
         S_CHECK: begin
            if (stale) begin
               pop     = 1'b1;
               state_d = S_IDLE;
               if (drop_cnt_q != 16'hFFFF) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
               end
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            pop     = 1'b1;
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            if (!REQ_COMMAND) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
      overflow_d = overflow_q | (CMD_WR & FULL);

      if (CLR) begin
         state_d    = S_IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         mem_out_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         mem_out_q  <= mem_out_d;
      end
   end

endmodule
